// File: rtl/mips_ctrl_pkg.sv
// Shared types and instruction-class decode for the multicycle MIPS sequencer.
// The class functions are the single place where opcode/function codes are
// interpreted, so the sequencer and any future decode users agree.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    EXEC    = 3'd1,
    MEM     = 3'd2,
    WB      = 3'd3,
    MD_WAIT = 3'd4,
    HALT    = 3'd5
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_ADDI    = 6'd8;
  localparam logic [5:0] OP_LUI     = 6'd15;
  localparam logic [5:0] OP_LB      = 6'd32;
  localparam logic [5:0] OP_LWR     = 6'd38;
  localparam logic [5:0] OP_SB      = 6'd40;
  localparam logic [5:0] OP_SH      = 6'd41;
  localparam logic [5:0] OP_SW      = 6'd43;

  // SPECIAL function codes (IR[5:0])
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  // LB, LH, LWL, LW, LBU, LHU, LWR
  function automatic logic is_load(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_LWR);
  endfunction

  // SB, SH, SW
  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // MULT, MULTU, DIV, DIVU
  function automatic logic is_multdiv(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) && (fn >= FN_MULT) && (fn <= FN_DIVU);
  endfunction

  // DIV, DIVU pick the long latency
  function automatic logic is_div(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) && ((fn == FN_DIV) || (fn == FN_DIVU));
  endfunction

  // MTHI, MTLO write HI/LO directly from a register
  function automatic logic is_mthilo(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) && ((fn == FN_MTHI) || (fn == FN_MTLO));
  endfunction

  // Register-writing class, matching the single-cycle decode. REGIMM is
  // included as a whole because rt is not visible here: the datapath routes
  // the non-linking branches to $zero, so only BxxAL has a visible effect.
  function automatic logic writes_reg(input logic [5:0] op, input logic [5:0] fn);
    logic wr;
    case (op)
      OP_SPECIAL: wr = !((fn == FN_JR) || (fn == FN_MTHI) || (fn == FN_MTLO) ||
                         is_multdiv(op, fn));
      OP_REGIMM:  wr = 1'b1;
      OP_JAL:     wr = 1'b1;
      default:    wr = (op >= OP_ADDI) && (op <= OP_LUI);
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/mips_ctrl_sequencer_md_latency_counter.sv
// Down-counter that times the MD_WAIT state for the variable-latency mult/div unit.
module md_latency_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= value;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mips_ctrl_sequencer.sv
// Multicycle control sequencer for the MIPS core. Owns the state register,
// drives Avalon-MM strobes and the datapath write enables. Outputs are a
// Moore function of state qualified by waitrequest, the IR fields and the
// halt compare; every strobe is forced low while reset is high.
module mips_ctrl_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR = {ADDR_W{1'b0}},
  parameter int                MULT_LAT  = 2,
  parameter int                DIV_LAT   = 32,
  parameter int                CNT_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              waitrequest,
  input  logic [5:0]        opcode,
  input  logic [5:0]        function_code,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [2:0]        state,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_we,
  output logic              pc_we,
  output logic              reg_we,
  output logic              md_start,
  output logic              hilo_we,
  output logic              active
);

  state_t state_r;
  state_t state_next_s;
  state_t state_pre_s;

  logic             md_load_s;
  logic             md_dec_s;
  logic             md_zero_s;
  logic [CNT_W-1:0] md_value_s;

  logic load_s;
  logic store_s;
  logic multdiv_s;

  assign load_s    = is_load(opcode);
  assign store_s   = is_store(opcode);
  assign multdiv_s = is_multdiv(opcode, function_code);

  // Counter preload is LAT-1 so MD_WAIT lasts exactly LAT cycles.
  assign md_value_s = is_div(opcode, function_code) ? CNT_W'(DIV_LAT - 1)
                                                    : CNT_W'(MULT_LAT - 1);

  md_latency_counter #(.W(CNT_W)) u_md_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (md_load_s),
    .value (md_value_s),
    .dec   (md_dec_s),
    .zero  (md_zero_s)
  );

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and strobe decode; a committed jump to HALT_ADDR overrides the next state.
  always_comb begin
    state_pre_s  = state_r;
    state_next_s = state_r;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    md_start     = 1'b0;
    hilo_we      = 1'b0;
    active       = 1'b1;
    md_load_s    = 1'b0;
    md_dec_s     = 1'b0;
    if (reset) begin
      state_next_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          mem_read = 1'b1;
          if (!waitrequest) begin
            ir_we       = 1'b1;
            state_pre_s = EXEC;
          end else begin
            state_pre_s = FETCH;
          end
        end
        EXEC: begin
          if (load_s || store_s) begin
            state_pre_s = MEM;
          end else if (multdiv_s) begin
            md_start    = 1'b1;
            md_load_s   = 1'b1;
            state_pre_s = MD_WAIT;
          end else begin
            pc_we       = 1'b1;
            reg_we      = writes_reg(opcode, function_code);
            hilo_we     = is_mthilo(opcode, function_code);
            state_pre_s = FETCH;
          end
        end
        MEM: begin
          if (load_s) begin
            mem_read    = 1'b1;
            state_pre_s = waitrequest ? MEM : WB;
          end else if (store_s) begin
            mem_write = 1'b1;
            if (!waitrequest) begin
              pc_we       = 1'b1;
              state_pre_s = FETCH;
            end else begin
              state_pre_s = MEM;
            end
          end else begin
            // IR is stable, so this only guards against a corrupted state.
            pc_we       = 1'b1;
            state_pre_s = FETCH;
          end
        end
        WB: begin
          reg_we      = 1'b1;
          pc_we       = 1'b1;
          state_pre_s = FETCH;
        end
        MD_WAIT: begin
          if (md_zero_s) begin
            hilo_we     = 1'b1;
            pc_we       = 1'b1;
            state_pre_s = FETCH;
          end else begin
            md_dec_s    = 1'b1;
            state_pre_s = MD_WAIT;
          end
        end
        HALT: begin
          active      = 1'b0;
          state_pre_s = HALT;
        end
        default: begin
          state_pre_s = FETCH;
        end
      endcase
      state_next_s = (pc_we && (pc_next == HALT_ADDR)) ? HALT : state_pre_s;
    end
  end

  assign state = state_r;

endmodule
